// File: rtl/i2s_pkg.sv
// Shared I2S definitions used by the master transmitter and the slave receiver.
//   i2s_state_e   : transmitter slot state (IDLE, LEFT, RIGHT)
//   DEF_DATA_W    : default sample width per channel
//   DEF_SLOT_BITS : default SCK periods per channel slot
package i2s_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2
  } i2s_state_e;

  localparam int DEF_DATA_W    = 16;
  localparam int DEF_SLOT_BITS = 18;

endpackage

// File: rtl/i2s_master_tx_if.sv
// Sample stream plus I2S bus bundle for the master transmitter.
//   s_valid/s_ready : sample pair handshake
//   s_left/s_right  : left/right samples
//   sck/ws/sd       : I2S bit clock, word select (1 = left), serial data
// Modport master is the transmitter's view; modport slave is the peer's view
// (sample source and bus receiver).
interface i2s_master_tx_if
  import i2s_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_left;
  logic [DATA_W-1:0] s_right;
  logic              sck;
  logic              ws;
  logic              sd;

  modport master (
    input  s_valid, s_left, s_right,
    output s_ready, sck, ws, sd
  );

  modport slave (
    output s_valid, s_left, s_right,
    input  s_ready, sck, ws, sd
  );
endinterface

// File: rtl/i2s_sck_gen.sv
// I2S bit clock generator.
//   clk/rstn  : system clock, async active-low reset
//   hold      : keep divider at 0 and sck low (transmitter idle)
//   clr       : one-shot return to the held state without toggling
//   sck       : registered bit clock, toggles every CLK_DIV clk
//   rise_tick : strobe, the current edge takes sck 0->1
//   fall_tick : strobe, the current edge takes sck 1->0
module i2s_sck_gen #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic hold,
  input  logic clr,
  output logic sck,
  output logic rise_tick,
  output logic fall_tick
);
  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q;
  logic          tick;

  // The divider idles at 0, so releasing hold toggles sck on that same edge.
  assign tick      = !hold && (cnt_q == '0);
  assign rise_tick = tick && !sck;
  assign fall_tick = tick && sck;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      sck   <= 1'b0;
    end else if (hold || clr) begin
      cnt_q <= '0;
      sck   <= 1'b0;
    end else if (tick) begin
      cnt_q <= CW'(CLK_DIV - 1);
      sck   <= !sck;
    end else begin
      cnt_q <= cnt_q - CW'(1);
    end
  end
endmodule

// File: rtl/i2s_master_tx.sv
// I2S master transmitter: takes left/right sample pairs on a valid/ready
// handshake and serialises them as WS-high-left / WS-low-right slots of
// SLOT_BITS bits (DATA_W data bits MSB first, then zero pad). WS and SD change
// with SCK rising; the receiver samples on SCK falling.
//   clk/rstn    : system clock, async active-low reset
//   enable      : run request, sampled at frame boundaries
//   bus         : sample handshake in, sck/ws/sd out
//   busy        : transmitter not idle
//   frame_start : one-clk pulse as a left slot begins
//   underrun    : one-clk pulse when a frame starts with no sample held
module i2s_master_tx
  import i2s_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int SLOT_BITS = DEF_SLOT_BITS,
  parameter int CLK_DIV   = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            enable,
  i2s_master_tx_if.master bus,
  output logic            busy,
  output logic            frame_start,
  output logic            underrun
);
  localparam logic [4:0] LAST_BIT = 5'(SLOT_BITS - 1);

  i2s_state_e state_q, state_d;
  logic [4:0] bit_q, bit_d;
  logic       ws_q, ws_d;
  logic       sd_q, sd_d;
  logic       fs_q, fs_d;
  logic       ur_q, ur_d;
  logic       cont_q;
  logic       hold_valid;
  logic       accept, start, load, hold_low, sck_clr, last_bit;
  logic       sck, rise_tick, fall_tick;

  logic signed [DATA_W-1:0] hold_l, hold_r;
  logic signed [DATA_W-1:0] sh_l, sh_r;

  // Slot bit idx of a word: data MSB first, zero beyond the data bits.
  function automatic logic slot_bit(input logic [DATA_W-1:0] w, input logic [4:0] idx);
    logic b;
    b = 1'b0;
    for (int i = 0; i < DATA_W; i++) begin
      if (int'(idx) == i) b = w[DATA_W-1-i];
    end
    return b;
  endfunction

  assign accept      = bus.s_valid && !hold_valid;
  assign bus.s_ready = !hold_valid;
  assign start       = enable && hold_valid;
  assign hold_low    = (state_q == IDLE) && !start;
  assign last_bit    = (bit_q == LAST_BIT);

  i2s_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
    .clk       (clk),
    .rstn      (rstn),
    .hold      (hold_low),
    .clr       (sck_clr),
    .sck       (sck),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  // Holding register: one pair of look-ahead, emptied by each shadow load.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)       hold_valid <= 1'b0;
    else if (accept) hold_valid <= 1'b1;
    else if (load)   hold_valid <= 1'b0;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_l <= bus.s_left;
      hold_r <= bus.s_right;
    end
    if (load) begin
      sh_l <= hold_valid ? hold_l : '0;
      sh_r <= hold_valid ? hold_r : '0;
    end
  end

  // Continue-or-stop is decided on the last falling edge of the right slot,
  // so the whole frame is committed before enable is looked at.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)
      cont_q <= 1'b0;
    else if (fall_tick && (state_q == RIGHT) && last_bit)
      cont_q <= enable;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      bit_q   <= '0;
      ws_q    <= 1'b0;
      sd_q    <= 1'b0;
      fs_q    <= 1'b0;
      ur_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      ws_q    <= ws_d;
      sd_q    <= sd_d;
      fs_q    <= fs_d;
      ur_q    <= ur_d;
    end
  end

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    ws_d    = ws_q;
    sd_d    = sd_q;
    fs_d    = 1'b0;
    ur_d    = 1'b0;
    load    = 1'b0;
    sck_clr = 1'b0;
    unique case (state_q)
      IDLE: begin
        bit_d = '0;
        ws_d  = 1'b0;
        sd_d  = 1'b0;
        // rise_tick only fires here when start released the divider
        if (rise_tick) begin
          state_d = LEFT;
          load    = 1'b1;
          ws_d    = 1'b1;
          sd_d    = hold_l[DATA_W-1];
          fs_d    = 1'b1;
        end
      end
      LEFT: begin
        if (rise_tick) begin
          if (last_bit) begin
            state_d = RIGHT;
            bit_d   = '0;
            ws_d    = 1'b0;
            sd_d    = sh_r[DATA_W-1];
          end else begin
            bit_d = bit_q + 5'd1;
            sd_d  = slot_bit(sh_l, bit_q + 5'd1);
          end
        end
      end
      RIGHT: begin
        if (rise_tick) begin
          if (last_bit) begin
            bit_d = '0;
            if (cont_q) begin
              state_d = LEFT;
              load    = 1'b1;
              ws_d    = 1'b1;
              sd_d    = hold_valid && hold_l[DATA_W-1];
              fs_d    = 1'b1;
              ur_d    = !hold_valid;
            end else begin
              state_d = IDLE;
              ws_d    = 1'b0;
              sd_d    = 1'b0;
              sck_clr = 1'b1;
            end
          end else begin
            bit_d = bit_q + 5'd1;
            sd_d  = slot_bit(sh_r, bit_q + 5'd1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.sck     = sck;
  assign bus.ws      = ws_q;
  assign bus.sd      = sd_q;
  assign busy        = (state_q != IDLE);
  assign frame_start = fs_q;
  assign underrun    = ur_q;
endmodule

// File: tb/tb_i2s_master_tx.sv
module tb_i2s_master_tx;
  localparam int DATA_W    = 16;
  localparam int SLOT_BITS = 18;
  localparam int CLK_DIV   = 2;
  localparam int BIT_CLK   = 2 * CLK_DIV;
  localparam int SLOT_CLK  = SLOT_BITS * BIT_CLK;
  localparam int FRAME_CLK = 2 * SLOT_CLK;

  localparam int PH_IDLE = 0, PH_SINGLE = 1, PH_STREAM = 2;
  localparam int PH_UNDER = 3, PH_DROP = 4, PH_RST = 5;

  typedef struct packed {
    logic              ws;
    logic [DATA_W-1:0] w;
  } slot_t;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic enable = 1'b0;
  logic busy, frame_start, underrun;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int phase = PH_IDLE;
  int fs_cnt = 0;
  int ur_cnt = 0;
  slot_t exp_q[$];

  i2s_master_tx_if #(.DATA_W(DATA_W)) bus ();

  i2s_master_tx #(
    .DATA_W   (DATA_W),
    .SLOT_BITS(SLOT_BITS),
    .CLK_DIV  (CLK_DIV)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .enable     (enable),
    .bus        (bus),
    .busy       (busy),
    .frame_start(frame_start),
    .underrun   (underrun)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, want);
    end
  endtask

  task automatic note_timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got timeout, want event within budget", name);
  endtask

  // Monitor: decodes slots at sck falling edges and scores them.
  logic [SLOT_BITS-1:0] sh;
  int    nb = 0;
  logic  first_ws, sck_d, ws_d;
  int    last_fs, last_ws, mon_phase = -1;
  bit    have_fs, have_ws;
  slot_t e;

  always @(negedge clk) begin
    if (phase != mon_phase) begin
      have_fs   = 1'b0;
      have_ws   = 1'b0;
      mon_phase = phase;
    end
    if (!rstn) begin
      nb    = 0;
      sck_d = 1'b0;
      ws_d  = 1'b0;
    end else begin
      if (frame_start) begin
        fs_cnt++;
        if (phase == PH_STREAM && have_fs) check("fs_spacing", 32'(cyc - last_fs), 32'(FRAME_CLK));
        last_fs = cyc;
        have_fs = 1'b1;
      end
      if (underrun) begin
        ur_cnt++;
        check("underrun_with_frame_start", 32'(frame_start), 32'd1);
      end
      if (bus.ws != ws_d) begin
        if (phase == PH_UNDER && have_ws) check("ws_gap", 32'(cyc - last_ws), 32'(SLOT_CLK));
        last_ws = cyc;
        have_ws = 1'b1;
      end
      ws_d = bus.ws;
      if (sck_d && !bus.sck) begin
        if (nb == 0) first_ws = bus.ws;
        sh = {sh[SLOT_BITS-2:0], bus.sd};
        nb++;
        if (nb == SLOT_BITS) begin
          nb = 0;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL slot_unexpected: got ws=%0b bits=0x%0h, want no slot", bus.ws, sh);
          end else begin
            e = exp_q.pop_front();
            check("slot", 32'({first_ws, bus.ws, sh}), 32'({e.ws, e.ws, e.w, 2'b00}));
          end
        end
      end
      sck_d = bus.sck;
    end
  end

  // Stimulus helpers (entered #1 after a rising clk edge).
  task automatic offer(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    bus.s_valid = 1'b1;
    bus.s_left  = l;
    bus.s_right = r;
    exp_q.push_back('{1'b1, l});
    exp_q.push_back('{1'b0, r});
  endtask

  task automatic wait_accept();
    int n = 0;
    while (!bus.s_ready && n < 4 * FRAME_CLK) begin
      @(posedge clk); #1;
      n++;
    end
    if (!bus.s_ready) note_timeout("wait_accept");
    else begin
      @(posedge clk); #1;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [DATA_W-1:0] l, input logic [DATA_W-1:0] r);
    offer(l, r);
    wait_accept();
  endtask

  task automatic wait_fs(input int target);
    int n = 0;
    while (fs_cnt < target && n < 3 * FRAME_CLK) begin
      @(posedge clk); #1;
      n++;
    end
    if (fs_cnt < target) note_timeout("wait_frame_start");
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3 * FRAME_CLK) begin
      @(posedge clk); #1;
      n++;
    end
    if (busy) note_timeout("wait_idle");
  endtask

  logic [DATA_W-1:0] st_l [4] = '{16'h1234, 16'h8000, 16'hFFFF, 16'h5A5A};
  logic [DATA_W-1:0] st_r [4] = '{16'hFEDC, 16'h0001, 16'h0000, 16'hC3A5};

  initial begin
    int fs0, ur0, act;
    bus.s_valid = 1'b0;
    bus.s_left  = '0;
    bus.s_right = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 32'({bus.sck, bus.ws, bus.sd, busy, frame_start, underrun, bus.s_ready}),
          32'b0000001);
    @(posedge clk); #1 rstn = 1'b1;

    // Idle with enable low
    act = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.sck || bus.ws || bus.sd || busy || frame_start || underrun || !bus.s_ready) act++;
    end
    check("idle_1000", 32'(act), 32'd0);

    // Single pair
    @(posedge clk); #1;
    phase  = PH_SINGLE;
    fs0    = fs_cnt;
    enable = 1'b1;
    send_pair(16'hA5C3, 16'h0F0F);
    wait_fs(fs0 + 1);
    enable = 1'b0;
    wait_idle();
    check("single_fs_count", 32'(fs_cnt - fs0), 32'd1);
    check("single_idle_bus", 32'({busy, bus.sck, bus.ws, bus.sd}), 32'd0);

    // Four pairs back to back
    phase  = PH_STREAM;
    fs0    = fs_cnt;
    ur0    = ur_cnt;
    enable = 1'b1;
    for (int i = 0; i < 4; i++) send_pair(st_l[i], st_r[i]);
    wait_fs(fs0 + 4);
    enable = 1'b0;
    wait_idle();
    check("stream_fs_count", 32'(fs_cnt - fs0), 32'd4);
    check("stream_no_underrun", 32'(ur_cnt - ur0), 32'd0);

    // Underrun: one pair, enable held into the second frame
    phase  = PH_UNDER;
    fs0    = fs_cnt;
    ur0    = ur_cnt;
    enable = 1'b1;
    send_pair(16'hC001, 16'h8003);
    exp_q.push_back('{1'b1, 16'h0000});
    exp_q.push_back('{1'b0, 16'h0000});
    wait_fs(fs0 + 2);
    enable = 1'b0;
    wait_idle();
    check("underrun_count", 32'(ur_cnt - ur0), 32'd1);
    check("underrun_fs_count", 32'(fs_cnt - fs0), 32'd2);

    // enable dropped at LEFT bit 3, next pair held off until restart
    phase  = PH_DROP;
    fs0    = fs_cnt;
    enable = 1'b1;
    send_pair(16'h0F0F, 16'hF0F0);
    wait_fs(fs0 + 1);
    send_pair(16'h6996, 16'h9669);
    repeat (3 * BIT_CLK + 2) @(posedge clk);
    #1 enable = 1'b0;
    wait_idle();
    check("drop_fs_count", 32'(fs_cnt - fs0), 32'd1);
    check("drop_idle_bus", 32'({busy, bus.sck, bus.ws, bus.sd}), 32'd0);
    offer(16'h0123, 16'h4567);
    act = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.s_ready || busy) act++;
    end
    check("drop_backpressure", 32'(act), 32'd0);
    @(posedge clk); #1;
    fs0    = fs_cnt;
    enable = 1'b1;
    wait_accept();
    wait_fs(fs0 + 2);
    enable = 1'b0;
    wait_idle();
    check("restart_fs_count", 32'(fs_cnt - fs0), 32'd2);

    // Async reset at RIGHT bit 7 with a pair held
    phase  = PH_RST;
    fs0    = fs_cnt;
    enable = 1'b1;
    send_pair(16'h3C3C, 16'hC3C3);
    wait_fs(fs0 + 1);
    send_pair(16'h1111, 16'h2222);
    repeat (SLOT_CLK + 7 * BIT_CLK) @(posedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({bus.sck, bus.ws, bus.sd, busy, frame_start, underrun, bus.s_ready}), 32'b0000001);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("post_reset_ready_idle", 32'({bus.s_ready, busy}), 32'b10);
    @(posedge clk); #1;
    fs0 = fs_cnt;
    send_pair(16'h8001, 16'h7FFE);
    wait_fs(fs0 + 1);
    enable = 1'b0;
    wait_idle();
    check("post_reset_fs_count", 32'(fs_cnt - fs0), 32'd1);

    repeat (10) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no end of test, want completion within 40000 clk");
    $fatal(1);
  end
endmodule
